// File: rtl/glitcbus_pkg.sv
// rtl/glitcbus_pkg.sv - GLITCBUS encodings shared by the TISC master and GLITC slave
package glitcbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR_LO,
    ST_WDATA,
    ST_WCOMMIT,
    ST_RWAIT,
    ST_RDATA
  } state_e;

  typedef enum logic {
    GRDWR_WRITE = 1'b0,
    GRDWR_READ  = 1'b1
  } grdwr_e;

  localparam int unsigned ADR_BEATS = 2;
  localparam int unsigned DAT_BEATS = 4;
  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/glitcbus_slave.sv
// rtl/glitcbus_slave.sv - GLITC-side GLITCBUS endpoint: GAD byte bus to single-strobe register access
module glitcbus_slave
  import glitcbus_pkg::*;
#(
  parameter int unsigned READ_WAIT     = 2,
  parameter logic [31:0] TIMEOUT_DATA  = DEFAULT_TIMEOUT_DATA,
  parameter int unsigned WRITE_TIMEOUT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gsel_b_i,
  input  logic        grdwr_b_i,
  input  logic [7:0]  gad_i,
  output logic [7:0]  gad_o,
  output logic        gad_oe_o,
  output logic [15:0] reg_adr_o,
  output logic [31:0] reg_dat_o,
  output logic        reg_we_o,
  output logic        reg_stb_o,
  input  logic [31:0] reg_dat_i,
  input  logic        reg_ack_i,
  output logic        busy_o,
  output logic [7:0]  abort_cnt_o
);

  localparam logic [7:0] ADR_LAST = 8'(ADR_BEATS - 1);
  localparam logic [7:0] DAT_LAST = 8'(DAT_BEATS - 1);
  localparam logic [7:0] RW_LAST  = 8'(READ_WAIT - 1);
  localparam logic [7:0] WT_LAST  = 8'(WRITE_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        gsel_q;
  logic        rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdat_q, rdat_d;
  logic [7:0]  gad_q, gad_d;
  logic        gad_oe_q, gad_oe_d;
  logic [15:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic        stb_q, stb_d;
  logic        busy_q, busy_d;
  logic [7:0]  abort_q, abort_d;
  logic        abort_inc;
  logic [31:0] word;

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    rdat_d    = rdat_q;
    gad_d     = gad_q;
    gad_oe_d  = gad_oe_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    stb_d     = stb_q;
    abort_inc = 1'b0;
    word      = rdat_q;

    // WCOMMIT is deliberately absent: once all data bytes are in, the write completes.
    if (gsel_b_i && (state_q inside {ST_ADR_LO, ST_WDATA, ST_RWAIT, ST_RDATA})) begin
      state_d   = ST_IDLE;
      gad_oe_d  = 1'b1;
      stb_d     = 1'b0;
      we_d      = 1'b0;
      abort_inc = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gsel_q && !gsel_b_i) begin
            adr_d   = {adr_q[7:0], gad_i};
            rd_d    = (grdwr_b_i == GRDWR_READ);
            cnt_d   = 8'd1;
            state_d = ST_ADR_LO;
          end
        end
        ST_ADR_LO: begin
          adr_d = {adr_q[7:0], gad_i};
          if (cnt_q == ADR_LAST) begin
            cnt_d = '0;
            if (rd_q) begin
              stb_d   = 1'b1;
              we_d    = 1'b0;
              state_d = ST_RWAIT;
            end else begin
              state_d = ST_WDATA;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_WDATA: begin
          dat_d = {dat_q[23:0], gad_i};
          if (cnt_q == DAT_LAST) begin
            cnt_d   = '0;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            state_d = ST_WCOMMIT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_WCOMMIT: begin
          if (reg_ack_i || cnt_q == WT_LAST) begin
            abort_inc = !reg_ack_i;
            stb_d     = 1'b0;
            we_d      = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_RWAIT: begin
          if (stb_q && reg_ack_i) begin
            word  = reg_dat_i;
            stb_d = 1'b0;
          end else if (stb_q && cnt_q == RW_LAST) begin
            word      = TIMEOUT_DATA;
            stb_d     = 1'b0;
            abort_inc = 1'b1;
          end
          rdat_d = word;
          if (cnt_q == RW_LAST) begin
            gad_d    = word[31:24];
            gad_oe_d = 1'b0;
            rdat_d   = {word[23:0], 8'h00};
            cnt_d    = '0;
            state_d  = ST_RDATA;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_RDATA: begin
          if (cnt_q == DAT_LAST) begin
            gad_oe_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            gad_d  = rdat_q[31:24];
            rdat_d = {rdat_q[23:0], 8'h00};
            cnt_d  = cnt_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d  = (state_d != ST_IDLE);
    abort_d = (abort_inc && abort_q != 8'hFF) ? abort_q + 8'd1 : abort_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      gsel_q   <= 1'b1;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
      rdat_q   <= '0;
      gad_q    <= '0;
      gad_oe_q <= 1'b1;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      abort_q  <= '0;
    end else begin
      state_q  <= state_d;
      gsel_q   <= gsel_b_i;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      rdat_q   <= rdat_d;
      gad_q    <= gad_d;
      gad_oe_q <= gad_oe_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      stb_q    <= stb_d;
      busy_q   <= busy_d;
      abort_q  <= abort_d;
    end
  end

  assign gad_o       = gad_q;
  assign gad_oe_o    = gad_oe_q;
  assign reg_adr_o   = adr_q;
  assign reg_dat_o   = dat_q;
  assign reg_we_o    = we_q;
  assign reg_stb_o   = stb_q;
  assign busy_o      = busy_q;
  assign abort_cnt_o = abort_q;

endmodule

// File: tb/tb_glitcbus_slave.sv
// tb/tb_glitcbus_slave.sv - bench for glitcbus_slave: vector table, hand sequences, random vs timeline model
module tb_glitcbus_slave;

  localparam int          RW = 2;
  localparam int          WT = 8;
  localparam logic [31:0] TD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_i, gsel_b_i, grdwr_b_i, reg_we_o, reg_stb_o, reg_ack_i, gad_oe_o, busy_o;
  logic [7:0]  gad_i, gad_o, abort_cnt_o;
  logic [15:0] reg_adr_o;
  logic [31:0] reg_dat_o, reg_dat_i;

  glitcbus_slave #(.READ_WAIT(RW), .TIMEOUT_DATA(TD), .WRITE_TIMEOUT(WT)) dut (
    .clk_i(clk), .rst_i(rst_i), .gsel_b_i(gsel_b_i), .grdwr_b_i(grdwr_b_i), .gad_i(gad_i),
    .gad_o(gad_o), .gad_oe_o(gad_oe_o), .reg_adr_o(reg_adr_o), .reg_dat_o(reg_dat_o),
    .reg_we_o(reg_we_o), .reg_stb_o(reg_stb_o), .reg_dat_i(reg_dat_i), .reg_ack_i(reg_ack_i),
    .busy_o(busy_o), .abort_cnt_o(abort_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [15:0] adr;
    logic [31:0] dat;
    int          d;         // ack delay in strobe cycles, -1 = never
    int          k;         // bus cycle in which GSEL_B goes high, -1 = never
    int          nbytes;
    logic [31:0] bytes;
    int          stb_cyc;
    int          stb_rise;
    int          oe_first;
    int          abort_inc;
  } vec_t;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, t0 = 0, m_abort = 0;
  int ack_delay = -1, stb_age = 0, pulse_cnt, stb_cycles, stb_rise_rel, oe_first_rel;
  logic        stb_prev = 1'b0, p_we;
  logic [15:0] p_adr;
  logic [31:0] p_dat, rsp_data = '0;
  logic [7:0]  rd_bytes[$];
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (reg_stb_o) begin
      if (!stb_prev) begin
        pulse_cnt++;
        p_adr = reg_adr_o;
        p_dat = reg_dat_o;
        p_we  = reg_we_o;
        stb_rise_rel = cyc - t0;
        stb_age = 0;
      end else begin
        stb_age++;
      end
      stb_cycles++;
    end
    stb_prev = reg_stb_o;
    if (!gad_oe_o) begin
      if (rd_bytes.size() == 0) oe_first_rel = cyc - t0;
      rd_bytes.push_back(gad_o);
    end
    reg_ack_i = reg_stb_o && ack_delay >= 0 && stb_age == ack_delay;
    reg_dat_i = rsp_data;
  endtask

  task automatic clear_obs();
    pulse_cnt = 0; stb_cycles = 0; stb_rise_rel = -1; oe_first_rel = -1;
    rd_bytes.delete();
  endtask

  task automatic run_txn(input logic is_rd, input logic [15:0] adr, input logic [31:0] dat,
                         input int d, input int k);
    int ncyc;
    clear_obs();
    ack_delay = d;
    rsp_data  = dat;
    gsel_b_i  = 1'b1;
    tick();
    ncyc = is_rd ? 6 + RW : 6;
    t0 = cyc;
    for (int c = 0; c < ncyc; c++) begin
      gsel_b_i  = (k >= 0 && c >= k);
      grdwr_b_i = (c == 0) ? is_rd : 1'($urandom_range(0, 1));
      if (c == 0)                   gad_i = adr[15:8];
      else if (c == 1)              gad_i = adr[7:0];
      else if (!is_rd && c <= 5)    gad_i = dat[8*(5-c) +: 8];
      else                          gad_i = 8'($urandom);
      tick();
      if (gsel_b_i) break;
    end
    gsel_b_i = 1'b1;
    repeat (WT + 3) tick();
  endtask

  // Expected outcome from the bus timeline: T0/T1 address, strobe visible from T2 (read)
  // or T6 (write), read bytes in T(2+RW)..T(5+RW), an abort ends the cycle GSEL_B is high.
  function automatic vec_t model(input logic is_rd, input logic [15:0] adr, input logic [31:0] dat,
                                 input int d, input int k);
    vec_t v;
    bit   acked;
    int   nat, lastc;
    logic [31:0] w;
    v = '{is_rd, adr, dat, d, k, 0, 32'h0, 0, -1, -1, 0};
    if (!is_rd) begin
      if (k >= 0) begin
        v.abort_inc = 1;
      end else begin
        v.stb_rise  = 6;
        v.stb_cyc   = (d >= 0 && d < WT) ? d + 1 : WT;
        v.abort_inc = (d >= 0 && d < WT) ? 0 : 1;
      end
    end else begin
      acked = d >= 0 && d < RW && (k < 0 || k > 2 + d);
      nat   = acked ? d + 1 : RW;
      v.stb_rise = (k == 1) ? -1 : 2;
      v.stb_cyc  = (k < 0) ? nat : ((k - 1 < nat) ? k - 1 : nat);
      lastc = (k < 0 || k > 5 + RW) ? 5 + RW : k;
      v.nbytes = lastc - (2 + RW) + 1;
      if (v.nbytes < 0) v.nbytes = 0;
      w = acked ? dat : TD;
      v.bytes = w & ~(32'hFFFF_FFFF >> (8 * v.nbytes));
      v.oe_first  = (v.nbytes > 0) ? 2 + RW : -1;
      v.abort_inc = ((k >= 0) ? 1 : 0) + (((k < 0 || k >= 2 + RW) && !acked) ? 1 : 0);
    end
    return v;
  endfunction

  task automatic check_txn(input string name, input vec_t e);
    logic [31:0] act;
    act = '0;
    for (int i = 0; i < rd_bytes.size() && i < 4; i++) act[31-8*i -: 8] = rd_bytes[i];
    m_abort = m_abort + e.abort_inc;
    if (m_abort > 255) m_abort = 255;
    chk({name, ".abort_cnt"}, 32'(abort_cnt_o), 32'(m_abort));
    chk({name, ".stb_cycles"}, stb_cycles, e.stb_cyc);
    chk({name, ".stb_rise"}, stb_rise_rel, e.stb_rise);
    chk({name, ".pulses"}, pulse_cnt, (e.stb_rise >= 0) ? 1 : 0);
    chk({name, ".nbytes"}, rd_bytes.size(), e.nbytes);
    chk({name, ".bytes"}, act, e.bytes);
    chk({name, ".oe_first"}, oe_first_rel, e.oe_first);
    chk({name, ".busy_end"}, 32'(busy_o), 32'd0);
    if (e.stb_rise >= 0) begin
      chk({name, ".adr"}, 32'(p_adr), 32'(e.adr));
      chk({name, ".we"}, 32'(p_we), 32'(!e.is_rd));
      if (!e.is_rd) chk({name, ".wdat"}, p_dat, e.dat);
    end
  endtask

  initial begin
    rst_i = 1'b1; gsel_b_i = 1'b1; grdwr_b_i = 1'b1; gad_i = '0; reg_ack_i = 1'b0; reg_dat_i = '0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    chk("rst.gad_o", 32'(gad_o), 32'h0);
    chk("rst.gad_oe", 32'(gad_oe_o), 32'h1);
    chk("rst.adr", 32'(reg_adr_o), 32'h0);
    chk("rst.dat", reg_dat_o, 32'h0);
    chk("rst.we_stb", {30'h0, reg_we_o, reg_stb_o}, 32'h0);
    chk("rst.busy", 32'(busy_o), 32'h0);
    chk("rst.abort", 32'(abort_cnt_o), 32'h0);

    //            rd    adr       dat            d   k  nb bytes          stb rise oe  ab
    tbl[0] = '{1'b0, 16'h1234, 32'hA5C30F01,  1, -1, 0, 32'h0,          2,  6, -1, 0};
    tbl[1] = '{1'b1, 16'h0040, 32'h11223344,  0, -1, 4, 32'h11223344,   1,  2,  4, 0};
    tbl[2] = '{1'b1, 16'h0080, 32'h0,        -1, -1, 4, 32'hDEADBEEF,   2,  2,  4, 1};
    tbl[3] = '{1'b0, 16'h5A5A, 32'h01020304,  0,  4, 0, 32'h0,          0, -1, -1, 1};
    tbl[4] = '{1'b0, 16'hBEEF, 32'h01234567,  0, -1, 0, 32'h0,          1,  6, -1, 0};
    tbl[5] = '{1'b0, 16'h0F0F, 32'hFFFF0000, -1, -1, 0, 32'h0,          8,  6, -1, 1};
    tbl[6] = '{1'b0, 16'h7001, 32'h89ABCDEF,  7, -1, 0, 32'h0,          8,  6, -1, 0};
    tbl[7] = '{1'b1, 16'h00A0, 32'hCAFEF00D,  1, -1, 4, 32'hCAFEF00D,   2,  2,  4, 0};
    tbl[8] = '{1'b1, 16'h0123, 32'h0,        -1,  3, 0, 32'h0,          2,  2, -1, 1};
    tbl[9] = '{1'b1, 16'h4455, 32'h11223344,  0,  5, 2, 32'h11220000,   1,  2,  4, 1};
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].is_rd, tbl[i].adr, tbl[i].dat, tbl[i].d, tbl[i].k);
      check_txn($sformatf("vec%0d", i), tbl[i]);
    end

    for (int i = 0; i < 40; i++) begin
      logic        is_rd;
      logic [15:0] adr;
      logic [31:0] dat;
      int          d, k;
      vec_t        e;
      is_rd = 1'($urandom_range(0, 1));
      adr   = 16'($urandom);
      dat   = $urandom;
      d     = int'($urandom_range(0, 10)) - 1;
      k     = -1;
      if ($urandom_range(0, 3) == 0) k = int'($urandom_range(1, is_rd ? 5 + RW : 5));
      e = model(is_rd, adr, dat, d, k);
      run_txn(is_rd, adr, dat, d, k);
      check_txn($sformatf("rnd%0d", i), e);
    end

    // Reset while the third read byte is on GAD must release the bus without a clock edge.
    clear_obs();
    ack_delay = 0; rsp_data = 32'h55667788; gsel_b_i = 1'b1;
    tick();
    t0 = cyc;
    for (int c = 0; c < 6; c++) begin
      gsel_b_i = 1'b0; grdwr_b_i = (c == 0); gad_i = (c == 0) ? 8'h00 : 8'h80;
      tick();
    end
    chk("rstmid.byte", 32'(gad_o), 32'h77);
    chk("rstmid.oe", 32'(gad_oe_o), 32'h0);
    chk("rstmid.busy", 32'(busy_o), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("rstmid.async_oe", 32'(gad_oe_o), 32'h1);
    chk("rstmid.outs", {gad_o, reg_adr_o[7:0], abort_cnt_o, 5'h0, reg_we_o, reg_stb_o, busy_o},
        32'h0);
    chk("rstmid.adr_dat", {reg_adr_o, reg_dat_o[15:0]} | {16'h0, reg_dat_o[31:16]}, 32'h0);
    #1 rst_i = 1'b0;
    gsel_b_i = 1'b1;
    m_abort = 0;
    run_txn(1'b1, 16'h0042, 32'h99887766, 0, -1);
    check_txn("after_rst", model(1'b1, 16'h0042, 32'h99887766, 0, -1));

    // GSEL_B held low after a write must not start a second transaction.
    clear_obs();
    ack_delay = 0; gsel_b_i = 1'b1;
    tick();
    t0 = cyc;
    for (int c = 0; c < 26; c++) begin
      gsel_b_i = 1'b0; grdwr_b_i = (c == 0) ? 1'b0 : 1'b1; gad_i = 8'(c + 1);
      tick();
    end
    chk("held_low.pulses", pulse_cnt, 1);
    chk("held_low.wdat", p_dat, 32'h03040506);
    chk("held_low.busy", 32'(busy_o), 32'h0);
    gsel_b_i = 1'b1;
    tick();

    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      gsel_b_i = 1'b1; tick();
      gsel_b_i = 1'b0; grdwr_b_i = 1'b0; tick();
      gsel_b_i = 1'b1; tick();
      if (i == 99)  chk("sat.100", 32'(abort_cnt_o), 32'd100);
      if (i == 254) chk("sat.255", 32'(abort_cnt_o), 32'd255);
    end
    chk("sat.300", 32'(abort_cnt_o), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
